// File: rtl/ckong_pkg.sv
// Shared definitions for the ckong ROM download path: address width, image length,
// loader state encoding and the running-checksum helper.
package ckong_pkg;

  localparam int                   CK_ROM_AW  = 17;
  localparam logic [CK_ROM_AW-1:0] CK_ROM_LEN = 17'h10000;

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_FAIL  = 3'd4
  } ldr_state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/ckong_hold_timer.sv
// Reload-and-count-down timer; done rises HOLD_CYC-1 enabled cycles after the last load.
module ckong_hold_timer #(
  parameter int HOLD_CYC = 16
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [15:0] LOAD_VAL = 16'(HOLD_CYC - 1);

  logic [15:0] cnt_r;

  // Load has priority over counting so a held request keeps the timer at full length.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= 16'd0;
      done  <= 1'b0;
    end else if (load) begin
      cnt_r <= LOAD_VAL;
      done  <= (LOAD_VAL == 16'd0);
    end else if (en && !done) begin
      cnt_r <= cnt_r - 16'd1;
      done  <= (cnt_r == 16'd1);
    end
  end

endmodule

// File: rtl/ckong_rom_loader.sv
// HPS download front end for ckong: validates the byte stream, tracks length/checksum,
// and owns the core reset so the core only ever runs from a complete, in-order image.
module ckong_rom_loader
  import ckong_pkg::*;
#(
  parameter logic [CK_ROM_AW-1:0] EXPECT_LEN = CK_ROM_LEN,
  parameter int                   HOLD_CYC   = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  input  logic                 rst_req,
  output logic [CK_ROM_AW-1:0] dn_addr,
  output logic [7:0]           dn_data,
  output logic                 dn_wr,
  output logic                 core_reset,
  output logic                 load_ok,
  output logic                 load_err,
  output logic [CK_ROM_AW-1:0] byte_count,
  output logic [7:0]           checksum
);

  ldr_state_t           state_r;
  logic                 dl_r, rise_r, fall_r, rst_req_r;
  logic                 seq_err_r, ovf_err_r;
  logic                 wr_ok_s, seq_hit_s, ovf_hit_s, good_s;
  logic                 timer_load_s, timer_en_s, timer_done_s;
  logic [CK_ROM_AW-1:0] count_next_s;

  ckong_hold_timer #(.HOLD_CYC(HOLD_CYC)) u_hold (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load    (timer_load_s),
    .en      (timer_en_s),
    .done    (timer_done_s)
  );

  // Download level capture and registered edge pulses; rst_req is also kept one cycle longer.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_r      <= 1'b0;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
      rst_req_r <= 1'b0;
    end else begin
      dl_r      <= ioctl_download;
      rise_r    <= ioctl_download & ~dl_r;
      fall_r    <= ~ioctl_download & dl_r;
      rst_req_r <= rst_req;
    end
  end

  // Classify the write presented this cycle: overflow beats ordering, and only LOAD accepts.
  always_comb begin
    wr_ok_s   = 1'b0;
    seq_hit_s = 1'b0;
    ovf_hit_s = 1'b0;
    if (state_r == S_LOAD && ioctl_wr) begin
      if (ioctl_addr >= {8'h00, EXPECT_LEN}) begin
        ovf_hit_s = 1'b1;
      end else if (ioctl_addr != {8'h00, byte_count}) begin
        seq_hit_s = 1'b1;
      end else begin
        wr_ok_s = 1'b1;
      end
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Completion is judged on post-write values so a write coinciding with the edge counts.
  always_comb begin
    count_next_s = byte_count + {{(CK_ROM_AW-1){1'b0}}, wr_ok_s};
    good_s       = (count_next_s == EXPECT_LEN) && !seq_err_r && !seq_hit_s
                   && !ovf_err_r && !ovf_hit_s;
    timer_en_s   = (state_r == S_HOLD);
    timer_load_s = (state_r == S_LOAD && fall_r && good_s)
                 || (state_r == S_RUN && rst_req)
                 || (state_r == S_HOLD && (rst_req || rst_req_r));
  end

  // Loader FSM with write staging, counters and registered status outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_EMPTY;
      core_reset <= 1'b1;
      dn_wr      <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= 8'h00;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
      byte_count <= '0;
      checksum   <= 8'h00;
      seq_err_r  <= 1'b0;
      ovf_err_r  <= 1'b0;
    end else begin
      dn_wr <= wr_ok_s;
      if (wr_ok_s) begin
        dn_addr    <= ioctl_addr[CK_ROM_AW-1:0];
        dn_data    <= ioctl_dout;
        byte_count <= count_next_s;
        checksum   <= csum_add(checksum, ioctl_dout);
      end
      if (seq_hit_s) seq_err_r <= 1'b1;
      if (ovf_hit_s) ovf_err_r <= 1'b1;

      if (rise_r && (state_r == S_EMPTY || state_r == S_RUN || state_r == S_FAIL)) begin
        state_r    <= S_LOAD;
        core_reset <= 1'b1;
        byte_count <= '0;
        checksum   <= 8'h00;
        load_ok    <= 1'b0;
        load_err   <= 1'b0;
        seq_err_r  <= 1'b0;
        ovf_err_r  <= 1'b0;
      end else begin
        case (state_r)
          S_EMPTY: core_reset <= 1'b1;
          S_LOAD: begin
            core_reset <= 1'b1;
            if (fall_r) begin
              if (good_s) begin
                state_r <= S_HOLD;
              end else begin
                state_r  <= S_FAIL;
                load_err <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (!(rst_req || rst_req_r) && timer_done_s) begin
              state_r    <= S_RUN;
              core_reset <= 1'b0;
              load_ok    <= 1'b1;
            end else begin
              core_reset <= 1'b1;
            end
          end
          S_RUN: begin
            if (rst_req) begin
              state_r    <= S_HOLD;
              core_reset <= 1'b1;
            end else begin
              core_reset <= 1'b0;
            end
          end
          S_FAIL: begin
            core_reset <= 1'b1;
            load_err   <= 1'b1;
          end
          default: begin
            state_r    <= S_EMPTY;
            core_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ckong_rom_loader.sv
// Self-checking bench for ckong_rom_loader: scenario table, hand sequences for reset
// corner cases, and randomized downloads against a stream-level reference model.
module tb_ckong_rom_loader;

  localparam logic [16:0] LEN = 17'd16;
  localparam int          HC  = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr, rst_req;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] dn_addr, byte_count;
  logic [7:0]  dn_data, checksum;
  logic        dn_wr, core_reset, load_ok, load_err;

  ckong_rom_loader #(.EXPECT_LEN(LEN), .HOLD_CYC(HC)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .rst_req        (rst_req),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .core_reset     (core_reset),
    .load_ok        (load_ok),
    .load_err       (load_err),
    .byte_count     (byte_count),
    .checksum       (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  bit          st_wr[$];
  logic [24:0] st_addr[$];
  logic [7:0]  st_data[$];
  int          obs_pulses;

  typedef struct {
    string      name;
    int         skip2;      // 1: address 2 is skipped in the stream
    int         n;
    int         drop_back;  // download drop happens this many items before stream end
    bit         exp_good;
    int         exp_pulses;
    int         exp_cnt;
    logic [7:0] exp_sum;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, " dn_wr"},      32'(dn_wr),      32'd0);
    chk({tag, " dn_addr"},    32'(dn_addr),    32'd0);
    chk({tag, " dn_data"},    32'(dn_data),    32'd0);
    chk({tag, " load_ok"},    32'(load_ok),    32'd0);
    chk({tag, " load_err"},   32'(load_err),   32'd0);
    chk({tag, " byte_count"}, 32'(byte_count), 32'd0);
    chk({tag, " checksum"},   32'(checksum),   32'd0);
  endtask

  // Run one download of the queued stream and check every cycle against the stream rules.
  task automatic play(input int drop_back);
    int n, c_drop, dec_c, cnt;
    logic [7:0] sum;
    bit seq, ovf, good, in_load, acc;
    n = st_wr.size();
    c_drop = n - drop_back;
    dec_c = c_drop + 1;
    cnt = 0; sum = 8'h00; seq = 1'b0; ovf = 1'b0; good = 1'b0;
    obs_pulses = 0;
    ioctl_download = 1'b1;
    @(posedge clk_sys); @(posedge clk_sys); #1;
    for (int c = 0; c <= dec_c + HC + 1; c++) begin
      if (c < n) begin
        ioctl_wr = st_wr[c]; ioctl_addr = st_addr[c]; ioctl_dout = st_data[c];
      end else begin
        ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'h00;
      end
      if (c == c_drop) ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
      in_load = (c <= dec_c);
      acc = 1'b0;
      if (in_load && c < n && st_wr[c]) begin
        if (st_addr[c] >= 25'(LEN)) ovf = 1'b1;
        else if (st_addr[c] != 25'(cnt)) seq = 1'b1;
        else acc = 1'b1;
      end
      if (acc) begin
        cnt++;
        sum = sum + st_data[c];
      end
      if (c == dec_c) good = (cnt == int'(LEN)) && !seq && !ovf;
      if (dn_wr) obs_pulses++;
      chk($sformatf("dn_wr c%0d", c), 32'(dn_wr), 32'(acc));
      if (acc) begin
        chk($sformatf("dn_addr c%0d", c), 32'(dn_addr), 32'(st_addr[c]));
        chk($sformatf("dn_data c%0d", c), 32'(dn_data), 32'(st_data[c]));
      end
      chk($sformatf("byte_count c%0d", c), 32'(byte_count), 32'(cnt));
      chk($sformatf("checksum c%0d", c), 32'(checksum), 32'(sum));
      if (c < dec_c) begin
        chk($sformatf("core_reset load c%0d", c), 32'(core_reset), 32'd1);
        chk($sformatf("load_ok load c%0d", c), 32'(load_ok), 32'd0);
        chk($sformatf("load_err load c%0d", c), 32'(load_err), 32'd0);
      end else if (good) begin
        chk($sformatf("core_reset hold c%0d", c), 32'(core_reset), 32'(c < dec_c + HC));
        chk($sformatf("load_ok hold c%0d", c), 32'(load_ok), 32'(c >= dec_c + HC));
        chk($sformatf("load_err hold c%0d", c), 32'(load_err), 32'd0);
      end else begin
        chk($sformatf("core_reset fail c%0d", c), 32'(core_reset), 32'd1);
        chk($sformatf("load_ok fail c%0d", c), 32'(load_ok), 32'd0);
        chk($sformatf("load_err fail c%0d", c), 32'(load_err), 32'd1);
      end
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic build_seq(input int n, input int skip2, input logic [7:0] d);
    st_wr.delete(); st_addr.delete(); st_data.delete();
    for (int i = 0; i < n; i++) begin
      st_wr.push_back(1'b1);
      st_addr.push_back((skip2 != 0 && i >= 2) ? 25'(i + 1) : 25'(i));
      st_data.push_back(d);
    end
  endtask

  initial begin
    int hi, low_cnt, nxt, n;
    bit seen_low, w;
    logic [24:0] a;

    vecs[0] = '{"clean",      0, 16, 0, 1'b1, 16, 16, 8'h10};
    vecs[1] = '{"skip",       1, 16, 0, 1'b0,  2,  2, 8'h22};
    vecs[2] = '{"overflow",   0, 17, 0, 1'b0, 16, 16, 8'h10};
    vecs[3] = '{"short",      0, 10, 0, 1'b0, 10, 10, 8'haa};
    vecs[4] = '{"coinc_raw",  0, 16, 1, 1'b1, 16, 16, 8'h10};
    vecs[5] = '{"coinc_edge", 0, 16, 2, 1'b1, 16, 16, 8'h10};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; rst_req = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1 chk_reset_vals("in_reset");
    reset_n = 1'b1;
    @(posedge clk_sys); #1 chk_reset_vals("after_reset");

    // EMPTY ignores writes and user reset requests.
    ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h5a; rst_req = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
    chk("empty dn_wr", 32'(dn_wr), 32'd0);
    chk("empty byte_count", 32'(byte_count), 32'd0);
    chk("empty core_reset", 32'(core_reset), 32'd1);
    rst_req = 1'b0;
    repeat (HC + 3) @(posedge clk_sys);
    #1 chk("empty core_reset later", 32'(core_reset), 32'd1);

    for (int v = 0; v < 6; v++) begin
      build_seq(vecs[v].n, vecs[v].skip2, 8'h11);
      play(vecs[v].drop_back);
      chk({vecs[v].name, " pulses"},     32'(obs_pulses), 32'(vecs[v].exp_pulses));
      chk({vecs[v].name, " byte_count"}, 32'(byte_count), 32'(vecs[v].exp_cnt));
      chk({vecs[v].name, " checksum"},   32'(checksum),   32'(vecs[v].exp_sum));
      chk({vecs[v].name, " load_ok"},    32'(load_ok),    32'(vecs[v].exp_good));
      chk({vecs[v].name, " load_err"},   32'(load_err),   32'(!vecs[v].exp_good));
      chk({vecs[v].name, " core_reset"}, 32'(core_reset), 32'(!vecs[v].exp_good));
    end

    // rst_req is ignored in FAIL.
    build_seq(10, 0, 8'h07);
    play(0);
    rst_req = 1'b1;
    low_cnt = 0;
    for (int k = 0; k < HC + 8; k++) begin
      @(posedge clk_sys); #1;
      if (k == 2) rst_req = 1'b0;
      if (!core_reset || !load_err) low_cnt++;
    end
    chk("fail ignores rst_req", 32'(low_cnt), 32'd0);

    // 3-cycle rst_req in RUN holds the core for 3 + HOLD_CYC cycles.
    build_seq(16, 0, 8'h3c);
    play(0);
    chk("run before rst_req", 32'(core_reset), 32'd0);
    hi = 0; seen_low = 1'b0;
    rst_req = 1'b1;
    for (int k = 0; k < 60 && !seen_low; k++) begin
      @(posedge clk_sys); #1;
      if (k == 2) rst_req = 1'b0;
      if (core_reset) hi++;
      else seen_low = 1'b1;
    end
    chk("rst_req release seen", 32'(seen_low), 32'd1);
    chk("rst_req hold length", 32'(hi), 32'(3 + HC));
    chk("rst_req load_ok kept", 32'(load_ok), 32'd1);

    // Randomized streams with gaps, stray addresses and varied drop timing.
    for (int r = 0; r < 40; r++) begin
      st_wr.delete(); st_addr.delete(); st_data.delete();
      n = int'($urandom_range(16, 24));
      nxt = 0;
      for (int i = 0; i < n; i++) begin
        w = ($urandom_range(0, 7) != 0);
        if (w && $urandom_range(0, 15) == 0) a = 25'($urandom_range(0, 20));
        else a = 25'(nxt);
        if (w && a == 25'(nxt)) nxt++;
        st_wr.push_back(w);
        st_addr.push_back(a);
        st_data.push_back(8'($urandom));
      end
      play(int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a load.
    ioctl_download = 1'b1;
    @(posedge clk_sys); @(posedge clk_sys); #1;
    for (int i = 0; i < 5; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'hc3;
      @(posedge clk_sys); #1;
    end
    chk("midload dn_wr before reset", 32'(dn_wr), 32'd1);
    chk("midload byte_count before reset", 32'(byte_count), 32'd5);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midload_reset");
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 chk_reset_vals("post_midload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ckong_rom_loader.md
# ckong_rom_loader

Sits between the HPS download port (`ioctl_*` from `hps_io`) and the `ckong` core's ROM write port (`dn_addr`/`dn_data`/`dn_wr`). It does three things:
- registers and validates the byte stream;
- keeps a running byte count and an 8-bit additive checksum;
- owns the core reset, holding the core in reset until a complete, in-order image has loaded, then releasing it after a fixed hold time.

## Interface

Parameters:
- `EXPECT_LEN`, default `17'h10000`: exact image length in bytes; also the write-address limit.
- `HOLD_CYC`, default `16`: reset-hold cycles after a good load or a reset request (minimum 1).

Ports:
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_download`  in  1  level; high while a download is in progress.
- `ioctl_wr`  in  1  one-cycle write strobe.
- `ioctl_addr`  in  25  byte address of the write.
- `ioctl_dout`  in  8  byte data.
- `rst_req`  in  1  user reset request (OSD reset or button), level.
- `dn_addr`  out  17  registered ROM write address.
- `dn_data`  out  8  registered ROM write data.
- `dn_wr`  out  1  one-cycle ROM write strobe.
- `core_reset`  out  1  active-high reset to the core.
- `load_ok`  out  1  high when the last download completed cleanly.
- `load_err`  out  1  high when the last download failed.
- `byte_count`  out  17  bytes accepted in the current or last download.
- `checksum`  out  8  mod-256 sum of the accepted bytes.

## Operation

- **Reset values:** state `EMPTY`, `core_reset=1`, `dn_wr=0`, `dn_addr=0`, `dn_data=0`, `load_ok=0`, `load_err=0`, `byte_count=0`, `checksum=0`.
- **Download edge detection:** `ioctl_download` is registered once; a rising or falling edge is detected against that registered copy.
- **States:** `EMPTY`, `LOAD`, `HOLD`, `RUN`, `FAIL`.
- **EMPTY / RUN / FAIL, download rising edge:**
  - go to `LOAD`;
  - clear `byte_count`, `checksum`, `load_ok`, `load_err`, and the sticky flags `seq_err` and `ovf_err`;
  - drive `core_reset=1`.
- **LOAD, on `ioctl_wr`:**
  - `ioctl_addr >= EXPECT_LEN`: set `ovf_err`; no `dn_wr`.
  - otherwise, `ioctl_addr != byte_count`: set `seq_err`; no `dn_wr`.
  - otherwise: pulse `dn_wr`, `byte_count++`, `checksum += ioctl_dout` (wraps mod 256).
- **LOAD, download falling edge:**
  - go to `HOLD` when `byte_count==EXPECT_LEN`, `seq_err` and `ovf_err` are both clear, and no write is still in flight;
  - otherwise go to `FAIL`.
- **Write and falling edge in the same cycle:** the write is accepted first, and the completion check includes it.
- **HOLD:**
  - `core_reset=1` while the counter loads `HOLD_CYC-1` and counts down to 0;
  - then go to `RUN` and set `load_ok=1`.
- **RUN:** `core_reset=0`. `rst_req` high moves to `HOLD` and reloads the counter. `rst_req` held high keeps reloading the counter, so release comes `HOLD_CYC` cycles after `rst_req` falls.
- **FAIL:** `core_reset=1`, `load_err=1`. `rst_req` is ignored. The only exit is a new download.
- **EMPTY:** `rst_req` is ignored, because there is no valid image to run.
- **Writes outside LOAD:** `ioctl_wr` in any other state is ignored; no `dn_wr` and no counter update.
- **Reset mid-operation:** `reset_n` low at any time returns every output to its reset value immediately (asynchronous), including during `LOAD`.

## Timing

- `dn_wr`, `dn_addr` and `dn_data` are valid exactly 1 cycle after the accepted `ioctl_wr`.
- Back-to-back `ioctl_wr` every cycle is supported at full rate; there is no backpressure and no buffering beyond that one stage.
- `byte_count` and `checksum` update in the same cycle as `dn_wr`.
- The state change is visible 1 cycle after the registered download edge, which is 2 cycles after the raw `ioctl_download` transition.
- `core_reset` falls exactly `HOLD_CYC` cycles after `HOLD` is entered.
- `load_ok` rises in the same cycle that `core_reset` falls.
- `load_err` rises in the cycle `FAIL` is entered.

## Structure

- **Shared package `ckong_pkg`:**
  - state enum `ldr_state_t`;
  - constants `CK_ROM_AW=17` and `CK_ROM_LEN`, which top level uses to set `EXPECT_LEN`.
- **Sub-module `ckong_hold_timer`:**
  - inputs: load, count enable, `HOLD_CYC` parameter;
  - output: `done`;
  - the FSM uses it for both the post-load hold and the user-reset hold.
- **Placement:** instantiated in `emu`. Its `core_reset` is OR-ed with nothing else; it replaces the direct `RESET|status[0]|buttons[1]` connection. `rst_req` carries `status[0]|buttons[1]`.

## Test plan

- **Clean load:** with `EXPECT_LEN=16`, stream addresses 0..15 with data `8'h11`, then drop `ioctl_download`.
  - 16 `dn_wr` pulses, each 1 cycle after its `ioctl_wr`;
  - `byte_count=16`, `checksum=8'h10`;
  - `core_reset` falls `HOLD_CYC` cycles after `HOLD` is entered;
  - `load_ok=1`.
- **Skipped address:** stream 0,1,3..16.
  - exactly 2 `dn_wr` pulses;
  - `FAIL` reached, `load_err=1`, `core_reset` stays 1.
- **Overflow:** a 17th write at address 16.
  - no `dn_wr` for it; ends in `FAIL`.
- **Short image:** download ends after 10 bytes.
  - `FAIL`, `byte_count=10`.
- **Final write coincides with falling edge:** the last write arrives in the same cycle as the download falling edge.
  - the write is accepted and the FSM goes to `HOLD`.
- **User reset in RUN and reset mid-load:**
  - `rst_req` pulsed for 3 cycles in `RUN`: `core_reset` is high for 3 + `HOLD_CYC` cycles;
  - `reset_n` asserted during `LOAD` returns all outputs to reset values, `core_reset=1`.
